// File: rtl/banner_overlay_compositor_if.sv
// Pixel-stage bus between the sprite/board stages, the banner compositor and the encoder.
// master = upstream pixel source; slave = compositor.
interface banner_overlay_compositor_if;
   logic       stalemate_req;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       stalemate_on;
   logic [3:0] ovl_red, ovl_green, ovl_blue;
   logic [3:0] bg_red, bg_green, bg_blue;
   logic [3:0] red, green, blue;
   logic       banner_active;
   logic       blink_done;

   modport master (
      output stalemate_req, DrawX, DrawY, blank, stalemate_on,
             ovl_red, ovl_green, ovl_blue, bg_red, bg_green, bg_blue,
      input  red, green, blue, banner_active, blink_done
   );

   modport slave (
      input  stalemate_req, DrawX, DrawY, blank, stalemate_on,
             ovl_red, ovl_green, ovl_blue, bg_red, bg_green, bg_blue,
      output red, green, blue, banner_active, blink_done
   );
endinterface

// File: rtl/banner_overlay_compositor.sv
// Stalemate banner compositor: frame-synchronous blink/steady FSM plus registered
// keyed overlay of the banner sprite onto the board colour.
//
// state  | meaning
// IDLE   | no banner requested; background only
// SHOW   | visible phase of a blink
// HIDE   | hidden phase of a blink
// STEADY | blinking finished, banner held visible
module banner_overlay_compositor #(
   parameter int          BLINK_FRAMES = 30,
   parameter int          BLINK_COUNT  = 3,
   parameter logic [11:0] KEY_COLOR    = 12'h000
) (
   input logic                         vga_clk,
   input logic                         reset,
   banner_overlay_compositor_if.slave  bus
);
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam int BW = $clog2(BLINK_COUNT + 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_COUNT - 1);

   typedef enum logic [1:0] {IDLE, SHOW, HIDE, STEADY} state_t;

   state_t        state;
   logic [FW-1:0] frame_cnt;
   logic [BW-1:0] blink_cnt;
   logic          tick_q;
   logic          tick_cond;
   logic          frame_tick;
   logic          show_banner;
   logic [11:0]   ovl_rgb;
   logic [11:0]   bg_rgb;
   logic [11:0]   pix_next;

   assign tick_cond  = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);
   assign frame_tick = tick_cond && !tick_q;

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         frame_cnt         <= '0;
         blink_cnt         <= '0;
         tick_q            <= 1'b0;
         bus.banner_active <= 1'b0;
         bus.blink_done    <= 1'b0;
      end else begin
         tick_q <= tick_cond;
         if (frame_tick) begin
            if (state != IDLE && !bus.stalemate_req) begin
               // Dropped request aborts wherever we are; no partial blink finishes.
               state             <= IDLE;
               frame_cnt         <= '0;
               blink_cnt         <= '0;
               bus.banner_active <= 1'b0;
               bus.blink_done    <= 1'b0;
            end else begin
               unique case (state)
                  IDLE: begin
                     if (bus.stalemate_req) begin
                        state             <= SHOW;
                        frame_cnt         <= '0;
                        blink_cnt         <= '0;
                        bus.banner_active <= 1'b1;
                        bus.blink_done    <= 1'b0;
                     end
                  end
                  SHOW: begin
                     if (frame_cnt == FRAME_LAST) begin
                        state     <= HIDE;
                        frame_cnt <= '0;
                     end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                     end
                  end
                  HIDE: begin
                     if (frame_cnt == FRAME_LAST) begin
                        frame_cnt <= '0;
                        if (blink_cnt == BLINK_LAST) begin
                           state          <= STEADY;
                           bus.blink_done <= 1'b1;
                        end else begin
                           state     <= SHOW;
                           blink_cnt <= blink_cnt + BW'(1);
                        end
                     end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                     end
                  end
                  STEADY: ;
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

   assign show_banner = (state == SHOW) || (state == STEADY);
   assign ovl_rgb     = {bus.ovl_red, bus.ovl_green, bus.ovl_blue};
   assign bg_rgb      = {bus.bg_red, bus.bg_green, bus.bg_blue};

   always_comb begin
      pix_next = bg_rgb;
      if (!bus.blank)
         pix_next = 12'h000;
      else if (show_banner && bus.stalemate_on && ovl_rgb != KEY_COLOR)
         pix_next = ovl_rgb;
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         bus.red   <= 4'h0;
         bus.green <= 4'h0;
         bus.blue  <= 4'h0;
      end else begin
         {bus.red, bus.green, bus.blue} <= pix_next;
      end
   end
endmodule

// File: tb/tb_banner_overlay_compositor.sv
// Directed bench for banner_overlay_compositor with short blink parameters.
// Frames are abbreviated: one (0,0) pixel followed by the pixel under test.
module tb_banner_overlay_compositor;
   logic vga_clk = 1'b0;
   logic reset   = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   banner_overlay_compositor_if bus ();

   banner_overlay_compositor #(
      .BLINK_FRAMES (2),
      .BLINK_COUNT  (2),
      .KEY_COLOR    (12'h000)
   ) dut (
      .vga_clk (vga_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic set_xy(input int x, input int y);
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
   endtask

   function automatic logic [11:0] pix();
      return {bus.red, bus.green, bus.blue};
   endfunction

   // One abbreviated frame: the (0,0) tick pixel, then the sprite pixel (600,450).
   task automatic do_frame();
      set_xy(0, 0);
      cyc();
      set_xy(600, 450);
      cyc();
   endtask

   logic       vis_tbl  [1:9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic       done_tbl [1:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      bus.stalemate_req = 1'b0;
      bus.blank         = 1'b1;
      bus.stalemate_on  = 1'b1;
      {bus.ovl_red, bus.ovl_green, bus.ovl_blue} = 12'hF00;
      {bus.bg_red, bus.bg_green, bus.bg_blue}    = 12'hABC;
      set_xy(600, 450);

      // Reset held for 5 cycles
      repeat (5) cyc();
      check("reset_rgb", 32'(pix()), 32'h000);
      check("reset_active", 32'(bus.banner_active), 0);
      check("reset_done", 32'(bus.blink_done), 0);
      reset = 1'b0;
      cyc();
      check("post_reset_rgb", 32'(pix()), 32'hABC);
      check("post_reset_active", 32'(bus.banner_active), 0);

      // Request glitch between ticks is ignored
      bus.stalemate_req = 1'b1;
      repeat (100) cyc();
      check("glitch_active", 32'(bus.banner_active), 0);
      check("glitch_rgb", 32'(pix()), 32'hABC);
      bus.stalemate_req = 1'b0;
      do_frame();
      check("glitch_after_tick_active", 32'(bus.banner_active), 0);
      check("glitch_after_tick_rgb", 32'(pix()), 32'hABC);

      // Full blink sequence
      bus.stalemate_req = 1'b1;
      for (int f = 1; f <= 9; f++) begin
         do_frame();
         check($sformatf("blink_f%0d_rgb", f), 32'(pix()), vis_tbl[f] ? 32'hF00 : 32'hABC);
         check($sformatf("blink_f%0d_done", f), 32'(bus.blink_done), 32'(done_tbl[f]));
         check($sformatf("blink_f%0d_active", f), 32'(bus.banner_active), 1);
      end
      do_frame();
      check("steady_f10_rgb", 32'(pix()), 32'hF00);
      check("steady_f10_done", 32'(bus.blink_done), 1);

      // Blanking in STEADY, one cycle latency
      bus.blank = 1'b0;
      check("blank_latency_rgb", 32'(pix()), 32'hF00);
      cyc();
      check("blank_rgb", 32'(pix()), 32'h000);
      bus.blank = 1'b1;
      cyc();
      check("unblank_rgb", 32'(pix()), 32'hF00);

      // Drop request: back to IDLE
      bus.stalemate_req = 1'b0;
      do_frame();
      check("drop_steady_active", 32'(bus.banner_active), 0);
      check("drop_steady_done", 32'(bus.blink_done), 0);
      check("drop_steady_rgb", 32'(pix()), 32'hABC);

      // Transparency in SHOW
      bus.stalemate_req = 1'b1;
      do_frame();
      check("show_rgb", 32'(pix()), 32'hF00);
      {bus.ovl_red, bus.ovl_green, bus.ovl_blue} = 12'h000;
      cyc();
      check("key_color_rgb", 32'(pix()), 32'hABC);
      {bus.ovl_red, bus.ovl_green, bus.ovl_blue} = 12'hFFF;
      bus.stalemate_on = 1'b0;
      cyc();
      check("outside_rect_rgb", 32'(pix()), 32'hABC);
      bus.stalemate_on = 1'b1;
      cyc();
      check("inside_rect_white", 32'(pix()), 32'hFFF);
      {bus.ovl_red, bus.ovl_green, bus.ovl_blue} = 12'hF00;

      // Reach HIDE (frame 3) then drop request
      do_frame();
      do_frame();
      check("hide_rgb", 32'(pix()), 32'hABC);
      check("hide_active", 32'(bus.banner_active), 1);
      bus.stalemate_req = 1'b0;
      set_xy(0, 0);
      cyc();
      check("drop_hide_active_edge", 32'(bus.banner_active), 0);
      set_xy(600, 450);
      cyc();
      check("drop_hide_rgb", 32'(pix()), 32'hABC);

      // Async reset during SHOW at DrawY=200
      bus.stalemate_req = 1'b1;
      do_frame();
      set_xy(600, 200);
      cyc();
      check("pre_async_rgb", 32'(pix()), 32'hF00);
      #3;
      reset = 1'b1;
      #1;
      check("async_rgb", 32'(pix()), 32'h000);
      check("async_active", 32'(bus.banner_active), 0);
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
      check("post_async_rgb", 32'(pix()), 32'hABC);
      check("post_async_active", 32'(bus.banner_active), 0);
      repeat (3) cyc();
      check("post_async_still_idle", 32'(pix()), 32'hABC);
      do_frame();
      check("post_async_show_rgb", 32'(pix()), 32'hF00);
      check("post_async_show_active", 32'(bus.banner_active), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/banner_overlay_compositor.md
Name: banner_overlay_compositor

Overview:
- Pixel-stage compositor directly downstream of the stalemate banner sprite stage.
- Takes the sprite's in-region flag and palette RGB plus the board/background RGB.
- Decides frame-synchronously whether the banner is shown, blinks it a fixed number of times after the request, then holds it steady.
- Produces the registered final RGB that goes to the HDMI/VGA encoder.

Parameters:
- BLINK_FRAMES, 30: frames per visible phase and per hidden phase of one blink.
- BLINK_COUNT, 3: number of show/hide pairs before the banner is held steady.
- KEY_COLOR, 12'h000: sprite {r,g,b} value treated as transparent; the background shows through.

Ports:
- vga_clk  in  1  pixel clock, one pixel per cycle.
- reset  in  1  asynchronous, active-high.
- stalemate_req  in  1  level from game logic; banner wanted while high.
- DrawX  in  10  current pixel column (0..799).
- DrawY  in  10  current pixel row (0..524).
- blank  in  1  active-low blanking; 0 = outside the visible area.
- stalemate_on  in  1  sprite stage: pixel lies inside the banner rectangle.
- ovl_red, ovl_green, ovl_blue  in  4 each  sprite palette colour for this pixel.
- bg_red, bg_green, bg_blue  in  4 each  board/background colour for this pixel.
- red, green, blue  out  4 each  final registered pixel colour.
- banner_active  out  1  high while the FSM is in SHOW, HIDE or STEADY.
- blink_done  out  1  high while the FSM is in STEADY.

Behaviour:
- Reset (async, active-high):
  - red/green/blue = 0, banner_active = 0, blink_done = 0.
  - FSM = IDLE; frame counter = 0; blink counter = 0; frame-tick history flop = 0.
- Frame tick:
  - Condition: (DrawX==0 && DrawY==0).
  - frame_tick is asserted only on the cycle the condition rises (condition AND NOT the previous-cycle flop), so each frame gives exactly one tick.
- stalemate_req is sampled only on frame_tick. The banner state never changes mid-frame.
- FSM, evaluated only on frame_tick:
  - IDLE: req=1 -> SHOW; frame counter=0, blink counter=0.
  - SHOW: req=0 -> IDLE. Else frame counter==BLINK_FRAMES-1 -> HIDE, counter=0. Else counter+1.
  - HIDE: req=0 -> IDLE. Else counter==BLINK_FRAMES-1: if blink counter==BLINK_COUNT-1 -> STEADY, else -> SHOW and blink counter+1; counter=0 in both cases. Else counter+1.
  - STEADY: req=0 -> IDLE. Else stay.
- Counter widths:
  - Frame counter: $clog2(BLINK_FRAMES+1) bits.
  - Blink counter: $clog2(BLINK_COUNT+1) bits.
  - Neither counter wraps; both are cleared on entry to IDLE.
- Visibility:
  - show_banner = (state==SHOW || state==STEADY).
  - The FSM state updates on the edge that samples frame_tick, so the new state applies from the pixel after (0,0).
- Pixel select, combinational then registered (1 cycle latency, inputs at cycle N -> outputs at N+1):
  - blank==0 -> 0.
  - else show_banner && stalemate_on && {ovl}!=KEY_COLOR -> ovl.
  - else -> bg.
- banner_active and blink_done are registered and update on the same edge as the FSM state.
- Request edge cases:
  - A request that rises and falls between two frame ticks is ignored.
  - A request dropped during any state returns to IDLE at the next tick; no partial blink is completed.
- Reset mid-frame: outputs go to 0 immediately. Normal output resumes one cycle after reset deasserts. The banner does not appear before the first frame_tick that sees req=1.
- BLINK_COUNT==0 is illegal. BLINK_FRAMES>=1 is required.

Test Plan:
- Reset sequencing: hold reset for 5 cycles with bg=12'hABC and blank=1 -> red/green/blue=0 during reset. One cycle after release, output =12'hABC; banner_active=0.
- Blink timing: BLINK_FRAMES=2, BLINK_COUNT=2, req held high, sprite pixel (600,450) with ovl=12'hF00 -> at that pixel:
  - frames 1-2 = F00, frames 3-4 = bg, frames 5-6 = F00, frames 7-8 = bg;
  - from frame 9 on, F00 and blink_done=1.
- Transparency: in SHOW, stalemate_on=1 with ovl=KEY_COLOR (000) -> output = bg. With stalemate_on=0 and ovl=12'hFFF -> output = bg.
- Blanking: in STEADY, blank=0 at an in-rectangle pixel -> output 0, one cycle after the input.
- Request glitch: req pulses high for 100 cycles in mid-frame -> FSM stays IDLE and banner_active stays 0. Then req drops during HIDE -> IDLE at the next tick, and banner_active falls on that edge.
- Async reset during SHOW at DrawY=200 -> outputs are 0 within the same cycle. After release with req=1, the banner first shows in the frame following the next (0,0) tick.
